imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader for the instruction memory; the write-side counterpart of the core's read-only instruction fetch path.
- Accepts a framed byte stream, for example from a UART receiver, over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and issues one write per word into the instruction memory's write port.
- Holds the CPU core in reset from the start of a load until a verified image is in memory.

Parameters:
- DEPTH, 256, instruction memory capacity in words (1 KB at 256).
- AW, 8, word-index width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a load.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  32  byte address of the write; word aligned, so bits [1:0] are always 0.
- mem_wdata  out  32  instruction word to write.
- cpu_hold  out  1  hold the core in reset.
- busy  out  1  a load is in progress.
- done  out  1  last load completed with a good checksum (sticky).
- error  out  1  last load failed (sticky).
- words_loaded  out  AW+1  number of words written in the current or last load.

Behaviour:
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4*N payload bytes, each word little-endian (first byte goes to [7:0]).
  - CSUM: XOR of all payload bytes. The length bytes are excluded.
- Reset values: every output is 0; state is IDLE. Reset asserted mid-load returns to IDLE immediately, mem_we drops asynchronously, and any partial word is discarded.
- Handshake:
  - A byte is consumed on a rising edge where in_valid and in_ready are both 1.
  - in_ready is combinational from state: 1 in LEN0, LEN1, DATA and CSUM; 0 in IDLE, DONE and ERR.
  - in_valid with in_ready at 0 has no effect. Gaps of any length between bytes are legal.
- States:
  - IDLE/DONE/ERR: start moves to LEN0. On entry to LEN0: done, error, words_loaded, byte index, word index and checksum are cleared; busy and cpu_hold are set.
  - LEN0: on accept, latch LEN[7:0], go to LEN1.
  - LEN1: on accept, latch LEN[15:8]. Then:
    - N > DEPTH (compared at 17 bits): go to ERR.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: on each accept, place the byte in lane byte_idx and XOR it into the checksum. When byte_idx reaches 3:
    - Register mem_we=1, mem_addr={word_idx,2'b00} zero-extended to 32 bits, and mem_wdata=assembled word.
    - Increment word_idx and words_loaded.
    - If word_idx+1 == N, go to CSUM.
  - CSUM: on accept, compare the byte with the running XOR.
    - Equal: go to DONE. Set done=1, busy=0, cpu_hold=0.
    - Not equal: go to ERR. Set error=1, busy=0, cpu_hold stays 1.
  - ERR: the core stays held; memory may be partially written. Only a new start or rst leaves ERR.
- Write latency: mem_we is high for exactly one cycle, the cycle immediately after the edge that accepted the fourth byte. At back-to-back rate (4 cycles per word) writes never overlap.
- start is ignored while busy=1.
- start and a byte presented in the same cycle while in IDLE: the byte is not accepted, because in_ready is 0.
- Addresses wrap cannot occur: N is limited to at most DEPTH, so the highest address written is (DEPTH-1)*4.
- done and error are never 1 at the same time.

Test Plan:
- Normal load. Stimulus: start, then bytes 02 00 13 05 A0 00 93 05 10 00 30. Required response:
  - mem_we pulse 1: addr 0x0, data 0x00A00513.
  - mem_we pulse 2: addr 0x4, data 0x00100593.
  - Final outputs: done=1, error=0, cpu_hold=0, words_loaded=2.
- Bad checksum. Stimulus: same frame with CSUM=31. Required response: both writes still occur; error=1, done=0, cpu_hold=1, busy=0.
- Oversize length. Stimulus: 01 01 (N=257). Required response: ERR entered right after the second byte; no mem_we; in_ready=0; error=1.
- Zero-length frame. Stimulus: 00 00 00. Required response: done=1, no writes, words_loaded=0. Then repeat with a wrong CSUM of 5A: error=1.
- Flow control. Stimulus: normal load with random in_valid gaps of 0-5 cycles; in_valid=1 held while in IDLE; start pulsed mid-load. Required response: identical writes and outputs to the normal-load case; IDLE bytes are not consumed; the mid-load start is ignored.
- Asynchronous reset. Stimulus: rst asserted off-edge after bytes 01 00 13 05. Required response: all outputs 0 immediately, no write issued. Then a fresh start with 01 00 13 05 A0 00 B6 writes 0x00A00513 to addr 0x0 and sets done=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Loader-side bus bundle: byte stream in, instruction-memory write port out.
// The loader is the slave of the stream and drives the memory write strobe.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory.
// Holds the core in reset until a checksum-verified image has been written.
module imem_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t nxt;

    logic        acc;
    logic        start_ok;
    logic [7:0]  len_lo;
    logic [15:0] nlen;
    logic [16:0] len_n;
    logic [16:0] depth17;
    logic [1:0]  bidx;
    logic [AW:0] widx;
    logic [23:0] wbuf;
    logic [7:0]  csum;
    logic [16:0] wnext;
    logic        last_byte;
    logic        last_word;

    assign acc       = bus.in_valid & bus.in_ready;
    assign start_ok  = start & ((state == IDLE) | (state == DONE)
                                | (state == ERR));
    assign len_n     = {1'b0, bus.in_data, len_lo};
    assign depth17   = 17'(DEPTH);
    assign wnext     = 17'(widx) + 17'd1;
    assign last_byte = (bidx == 2'd3);
    assign last_word = (wnext == {1'b0, nlen});

    assign words_loaded = widx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) nxt = LEN0;
            end
            LEN0: begin
                if (acc) nxt = LEN1;
            end
            LEN1: begin
                if (acc) begin
                    if (len_n > depth17)
                        nxt = ERR;
                    else if (len_n == 17'd0)
                        nxt = CSUM;
                    else
                        nxt = DATA;
                end
            end
            DATA: begin
                if (acc && last_byte && last_word)
                    nxt = CSUM;
            end
            CSUM: begin
                if (acc)
                    nxt = (bus.in_data == csum) ? DONE : ERR;
            end
            default: nxt = IDLE;
        endcase
    end

    // Status is a pure function of state, so done/error stay sticky
    // until the next accepted start and can never both be high.
    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        cpu_hold     = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        unique case (state)
            LEN0, LEN1, DATA, CSUM: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                cpu_hold     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            ERR: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo        <= '0;
            nlen          <= '0;
            bidx          <= '0;
            widx          <= '0;
            wbuf          <= '0;
            csum          <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            if (start_ok) begin
                len_lo <= '0;
                nlen   <= '0;
                bidx   <= '0;
                widx   <= '0;
                wbuf   <= '0;
                csum   <= '0;
            end else if (acc) begin
                unique case (state)
                    LEN0: len_lo <= bus.in_data;
                    LEN1: nlen   <= {bus.in_data, len_lo};
                    DATA: begin
                        csum <= csum ^ bus.in_data;
                        bidx <= bidx + 2'd1;
                        unique case (bidx)
                            2'd0: wbuf[7:0]   <= bus.in_data;
                            2'd1: wbuf[15:8]  <= bus.in_data;
                            2'd2: wbuf[23:16] <= bus.in_data;
                            default: begin
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= {{(30-AW){1'b0}},
                                                  widx[AW-1:0], 2'b00};
                                bus.mem_wdata <= {bus.in_data, wbuf};
                                widx          <= widx + 1'b1;
                            end
                        endcase
                    end
                    default: begin
                        len_lo <= len_lo;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus
// time, a forked monitor pops and compares on every mem_we pulse.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] words_loaded;

    imem_loader_if ifc ();

    imem_loader #(.DEPTH(256), .AW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (ifc.slave),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nbad = 0;
    logic [63:0] expq[$];
    logic [63:0] e;
    logic        prev_we = 1'b0;
    logic [7:0]  frm[11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // busy, cpu_hold, done, error, in_ready, words_loaded
    task automatic chk_st(input string nm, input logic b, input logic h,
                          input logic d, input logic er, input logic r,
                          input logic [8:0] wl);
        chk(nm, 64'({busy, cpu_hold, done, error, ifc.in_ready,
                     words_loaded}),
            64'({b, h, d, er, r, wl}));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic gap(input int n);
        ifc.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        for (int k = 0; k < 50 && !ifc.in_ready; k++) @(negedge clk);
        if (!ifc.in_ready) begin
            chk("accept_timeout", 64'(ifc.in_ready), 64'd1);
            ifc.in_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic push_normal();
        expq.push_back({32'h0000_0000, 32'h00A0_0513});
        expq.push_back({32'h0000_0004, 32'h0010_0593});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        frm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                8'h93, 8'h05, 8'h10, 8'h00, 8'h30};

        fork
            forever begin
                @(negedge clk);
                if (ifc.mem_we) begin
                    chk("we_one_cycle", 64'(prev_we), 64'd0);
                    chk("write_expected", 64'(expq.size() != 0), 64'd1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        chk("write_addr_data",
                            {ifc.mem_addr, ifc.mem_wdata}, e);
                    end
                end
                prev_we = ifc.mem_we;
            end
        join_none

        repeat (2) @(negedge clk);
        chk_st("reset_status", 0, 0, 0, 0, 0, 9'd0);
        chk("reset_bus", 64'({ifc.mem_we, ifc.mem_addr[30:0],
                              ifc.mem_wdata}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // normal load
        push_normal();
        pulse_start();
        chk_st("started", 1, 1, 0, 0, 1, 9'd0);
        for (int i = 0; i < 11; i++) send(frm[i]);
        gap(3);
        chk_st("normal_end", 0, 0, 1, 0, 0, 9'd2);
        chk("normal_drained", 64'(expq.size()), 64'd0);

        // bad checksum: writes still happen
        push_normal();
        pulse_start();
        for (int i = 0; i < 10; i++) send(frm[i]);
        send(8'h31);
        gap(3);
        chk_st("badsum_end", 0, 1, 0, 1, 0, 9'd2);
        chk("badsum_drained", 64'(expq.size()), 64'd0);

        // oversize length, N=257
        pulse_start();
        send(8'h01);
        send(8'h01);
        chk_st("oversize_err", 0, 1, 0, 1, 0, 9'd0);
        gap(3);

        // zero-length frame, good then bad checksum
        pulse_start();
        send(8'h00);
        send(8'h00);
        send(8'h00);
        gap(2);
        chk_st("zero_done", 0, 0, 1, 0, 0, 9'd0);
        pulse_start();
        send(8'h00);
        send(8'h00);
        send(8'h5A);
        gap(2);
        chk_st("zero_badsum", 0, 1, 0, 1, 0, 9'd0);

        // flow control from a fresh IDLE
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h55;
        repeat (4) @(negedge clk);
        chk_st("idle_not_ready", 0, 0, 0, 0, 0, 9'd0);
        push_normal();
        pulse_start();
        for (int i = 0; i < 11; i++) begin
            gap($urandom_range(0, 5));
            if (i == 6) begin
                ifc.in_valid = 1'b0;
                pulse_start();
            end
            send(frm[i]);
        end
        gap(3);
        chk_st("flow_end", 0, 0, 1, 0, 0, 9'd2);
        chk("flow_drained", 64'(expq.size()), 64'd0);

        // asynchronous reset mid-word
        pulse_start();
        send(8'h01);
        send(8'h00);
        send(8'h13);
        send(8'h05);
        ifc.in_valid = 1'b0;
        chk_st("pre_reset", 1, 1, 0, 0, 1, 9'd0);
        #3;
        rst = 1'b1;
        #1;
        chk_st("async_reset", 0, 0, 0, 0, 0, 9'd0);
        chk("async_reset_we", 64'(ifc.mem_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        gap(2);
        expq.push_back({32'h0000_0000, 32'h00A0_0513});
        pulse_start();
        send(8'h01);
        send(8'h00);
        send(8'h13);
        send(8'h05);
        send(8'hA0);
        send(8'h00);
        send(8'hB6);
        gap(3);
        chk_st("after_reset_load", 0, 0, 1, 0, 0, 9'd1);
        chk("after_reset_drained", 64'(expq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
